// File: rtl/daric_axi_id_tracker.sv
// Per-ID outstanding-transaction limiter for one AXI address/response channel pair.
// Gates address ready/valid per ID, tracks totals, flags orphan completions, and offers a drain handshake.
module daric_axi_id_tracker #(
  parameter int IDW       = 4,
  parameter int MAX_OUTST = 8,
  parameter int TOT_W     = 8,
  localparam int NID      = 2 ** IDW,
  localparam int CW       = $clog2(MAX_OUTST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NID-1:0]   id_en_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [IDW-1:0]   req_id_i,
  output logic             req_valid_o,
  input  logic             req_ready_i,
  input  logic             rsp_valid_i,
  input  logic             rsp_ready_i,
  input  logic             rsp_last_i,
  input  logic [IDW-1:0]   rsp_id_i,
  input  logic             drain_req_i,
  output logic             drain_ack_o,
  output logic [TOT_W-1:0] tot_outst_o,
  output logic             err_orphan_o,
  output logic [IDW-1:0]   err_id_o,
  input  logic             err_clr_i
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DRAINED} state_e;

  localparam logic [TOT_W-1:0] TOT_MAX = {TOT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q [NID];
  logic [CW-1:0]    cnt_d [NID];
  logic [TOT_W-1:0] tot_q, tot_d;
  logic             err_q;
  logic [IDW-1:0]   err_id_q;

  logic allow, acc, cmp, same_id, orphan, tot_inc, tot_dec;

  assign allow = (state_q == ST_RUN) & id_en_i[req_id_i] & (cnt_q[req_id_i] < CW'(MAX_OUTST));
  assign req_valid_o = req_valid_i & allow;
  assign req_ready_o = req_ready_i & allow;

  assign acc     = req_valid_o & req_ready_i;
  assign cmp     = rsp_valid_i & rsp_ready_i & rsp_last_i;
  // A completion paired with a same-cycle accept on its ID is a matched pair, never an orphan.
  assign same_id = acc & cmp & (req_id_i == rsp_id_i);
  assign orphan  = cmp & (cnt_q[rsp_id_i] == '0) & ~same_id;
  assign tot_inc = acc & ~same_id;
  assign tot_dec = cmp & ~orphan & ~same_id;

  always_comb begin
    for (int i = 0; i < NID; i++) begin
      logic inc, dec;
      inc = acc & (req_id_i == IDW'(i));
      dec = cmp & (rsp_id_i == IDW'(i)) & ((cnt_q[i] != '0) | inc);
      cnt_d[i] = cnt_q[i];
      if (inc & ~dec) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (dec & ~inc) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
  end

  always_comb begin
    tot_d = tot_q;
    if (tot_inc & ~tot_dec) begin
      tot_d = (tot_q == TOT_MAX) ? tot_q : tot_q + TOT_W'(1);
    end else if (tot_dec & ~tot_inc) begin
      tot_d = (tot_q == '0) ? tot_q : tot_q - TOT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (drain_req_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!drain_req_i)        state_d = ST_RUN;
        else if (tot_q == '0)    state_d = ST_DRAINED;
      end
      ST_DRAINED: if (!drain_req_i) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      tot_q   <= '0;
      for (int i = 0; i < NID; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      tot_q   <= tot_d;
      for (int i = 0; i < NID; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // A new orphan outranks a same-cycle clear; only the first orphan ID is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q    <= 1'b0;
      err_id_q <= '0;
    end else if (orphan) begin
      err_q <= 1'b1;
      if (!err_q) err_id_q <= rsp_id_i;
    end else if (err_clr_i) begin
      err_q    <= 1'b0;
      err_id_q <= '0;
    end
  end

  assign drain_ack_o  = (state_q == ST_DRAINED);
  assign tot_outst_o  = tot_q;
  assign err_orphan_o = err_q;
  assign err_id_o     = err_id_q;

endmodule

// File: tb/tb_daric_axi_id_tracker.sv
// Scenario and randomized bench for daric_axi_id_tracker against a per-ID counting reference model.
module tb_daric_axi_id_tracker;

  localparam int IDW = 4, MAX = 8, TOTW = 8, NID = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NID-1:0]  id_en_i;
  logic            req_valid_i, req_ready_i, rsp_valid_i, rsp_ready_i, rsp_last_i;
  logic [IDW-1:0]  req_id_i, rsp_id_i;
  logic            drain_req_i, err_clr_i;
  logic            req_ready_o, req_valid_o, drain_ack_o, err_orphan_o;
  logic [TOTW-1:0] tot_outst_o;
  logic [IDW-1:0]  err_id_o;

  daric_axi_id_tracker #(.IDW(IDW), .MAX_OUTST(MAX), .TOT_W(TOTW)) dut (
    .clk(clk), .rst(rst), .id_en_i(id_en_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_id_i(req_id_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_i(rsp_ready_i), .rsp_last_i(rsp_last_i),
    .rsp_id_i(rsp_id_i), .drain_req_i(drain_req_i), .drain_ack_o(drain_ack_o),
    .tot_outst_o(tot_outst_o), .err_orphan_o(err_orphan_o), .err_id_o(err_id_o),
    .err_clr_i(err_clr_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: outstanding count per ID, running total, drain mode (0 run, 1 draining, 2 drained).
  int m_cnt [NID];
  int m_tot, m_mode, m_eid;
  bit m_err;

  function automatic bit m_allow();
    return (m_mode == 0) && id_en_i[req_id_i] && (m_cnt[req_id_i] < MAX);
  endfunction

  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_tot = 0; m_mode = 0; m_err = 0; m_eid = 0;
  endtask

  task automatic tick();
    bit acc, cmp, orph;
    int old_tot;
    acc = req_valid_i && req_ready_i && m_allow();
    cmp = rsp_valid_i && rsp_ready_i && rsp_last_i;
    orph = 0;
    old_tot = m_tot;
    if (!(acc && cmp && req_id_i == rsp_id_i)) begin
      if (acc) begin
        m_cnt[req_id_i]++;
        m_tot = (m_tot < 255) ? m_tot + 1 : 255;
      end
      if (cmp) begin
        if (m_cnt[rsp_id_i] > 0) begin
          m_cnt[rsp_id_i]--;
          m_tot = (m_tot > 0) ? m_tot - 1 : 0;
        end else begin
          orph = 1;
        end
      end
    end
    if (orph) begin
      if (!m_err) m_eid = int'(rsp_id_i);
      m_err = 1;
    end else if (err_clr_i) begin
      m_err = 0; m_eid = 0;
    end
    case (m_mode)
      0: if (drain_req_i) m_mode = 1;
      1: if (!drain_req_i) m_mode = 0; else if (old_tot == 0) m_mode = 2;
      default: if (!drain_req_i) m_mode = 0;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid_i = 0; req_ready_i = 1; req_id_i = '0;
    rsp_valid_i = 0; rsp_ready_i = 1; rsp_last_i = 1; rsp_id_i = '0;
    err_clr_i = 0;
  endtask

  task automatic drive_req(input bit v, input int id);
    req_valid_i = v; req_id_i = IDW'(id);
  endtask

  task automatic drive_rsp(input bit v, input bit last, input int id);
    rsp_valid_i = v; rsp_last_i = last; rsp_id_i = IDW'(id);
  endtask

  task automatic test_reset();
    idle();
    drain_req_i = 0; id_en_i = '1; rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    n_chk++; if (tot_outst_o !== 8'd0) begin n_fail++; $display("FAIL reset_tot got=%0d exp=0", tot_outst_o); end
    n_chk++; if (drain_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0", drain_ack_o); end
    n_chk++; if (err_orphan_o !== 1'b0 || err_id_o !== 4'd0) begin n_fail++; $display("FAIL reset_err got=%b/%h exp=0/0", err_orphan_o, err_id_o); end
    $display("reset: tot=%0d ack=%b err=%b", tot_outst_o, drain_ack_o, err_orphan_o);
  endtask

  task automatic test_basic();
    for (int k = 0; k < 3; k++) begin
      drive_req(1, 2);
      #1;
      n_chk++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL basic_ready k=%0d got=%b exp=1", k, req_ready_o); end
      tick();
      n_chk++; if (tot_outst_o !== TOTW'(k + 1)) begin n_fail++; $display("FAIL basic_acc_tot k=%0d got=%0d exp=%0d", k, tot_outst_o, k + 1); end
      $display("basic: accept id=2 tot=%0d", tot_outst_o);
    end
    drive_req(0, 0);
    for (int k = 0; k < 3; k++) begin
      drive_rsp(1, 1, 2);
      tick();
      n_chk++; if (tot_outst_o !== TOTW'(2 - k)) begin n_fail++; $display("FAIL basic_cmp_tot k=%0d got=%0d exp=%0d", k, tot_outst_o, 2 - k); end
      $display("basic: complete id=2 tot=%0d", tot_outst_o);
    end
    drive_rsp(0, 1, 0);
    n_chk++; if (err_orphan_o !== 1'b0) begin n_fail++; $display("FAIL basic_no_err got=%b exp=0", err_orphan_o); end
  endtask

  task automatic test_max();
    for (int k = 0; k < MAX; k++) begin drive_req(1, 5); tick(); end
    n_chk++; if (tot_outst_o !== 8'd8) begin n_fail++; $display("FAIL max_fill_tot got=%0d exp=8", tot_outst_o); end
    #1;
    n_chk++; if (req_ready_o !== 1'b0 || req_valid_o !== 1'b0) begin n_fail++; $display("FAIL max_block got=%b/%b exp=0/0", req_ready_o, req_valid_o); end
    drive_rsp(1, 1, 5);
    #1;
    n_chk++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL max_block_same_cycle got=%b exp=0", req_ready_o); end
    tick();
    drive_rsp(0, 1, 0);
    #1;
    n_chk++; if (req_ready_o !== 1'b1 || req_valid_o !== 1'b1) begin n_fail++; $display("FAIL max_resume got=%b/%b exp=1/1", req_ready_o, req_valid_o); end
    tick();
    n_chk++; if (tot_outst_o !== 8'd8) begin n_fail++; $display("FAIL max_ninth_tot got=%0d exp=8", tot_outst_o); end
    $display("max: ninth accepted tot=%0d", tot_outst_o);
    drive_req(0, 0);
    for (int k = 0; k < MAX; k++) begin drive_rsp(1, 1, 5); tick(); end
    drive_rsp(0, 1, 0);
    n_chk++; if (tot_outst_o !== 8'd0) begin n_fail++; $display("FAIL max_empty_tot got=%0d exp=0", tot_outst_o); end
  endtask

  task automatic test_same_id();
    for (int k = 0; k < 4; k++) begin drive_req(1, 3); tick(); end
    for (int k = 0; k < 2; k++) begin drive_req(1, 7); tick(); end
    drive_req(1, 3); drive_rsp(1, 1, 3);
    tick();
    n_chk++; if (tot_outst_o !== 8'd6) begin n_fail++; $display("FAIL same_id_tot got=%0d exp=6", tot_outst_o); end
    drive_req(1, 3); drive_rsp(1, 1, 7);
    tick();
    drive_rsp(0, 1, 0);
    n_chk++; if (tot_outst_o !== 8'd6 || m_cnt[3] != 5 || m_cnt[7] != 1) begin n_fail++; $display("FAIL cross_id_tot got=%0d exp=6", tot_outst_o); end
    $display("same_id: tot=%0d", tot_outst_o);
    for (int k = 0; k < 3; k++) begin drive_req(1, 3); tick(); end
    #1;
    n_chk++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL same_id_cnt_limit got=%b exp=0", req_ready_o); end
    drive_req(0, 0);
    for (int k = 0; k < MAX; k++) begin drive_rsp(1, 1, 3); tick(); end
    drive_rsp(1, 1, 7); tick();
    drive_rsp(0, 1, 0);
    n_chk++; if (tot_outst_o !== 8'd0 || err_orphan_o !== 1'b0) begin n_fail++; $display("FAIL same_id_clean got=%0d/%b exp=0/0", tot_outst_o, err_orphan_o); end
  endtask

  task automatic test_orphan();
    drive_rsp(1, 1, 10); tick();
    n_chk++; if (err_orphan_o !== 1'b1 || err_id_o !== 4'hA) begin n_fail++; $display("FAIL orphan_first got=%b/%h exp=1/a", err_orphan_o, err_id_o); end
    n_chk++; if (tot_outst_o !== 8'd0) begin n_fail++; $display("FAIL orphan_tot got=%0d exp=0", tot_outst_o); end
    drive_rsp(1, 1, 4); tick();
    n_chk++; if (err_orphan_o !== 1'b1 || err_id_o !== 4'hA) begin n_fail++; $display("FAIL orphan_keep got=%b/%h exp=1/a", err_orphan_o, err_id_o); end
    drive_rsp(0, 1, 0); err_clr_i = 1; tick(); err_clr_i = 0;
    n_chk++; if (err_orphan_o !== 1'b0 || err_id_o !== 4'h0) begin n_fail++; $display("FAIL orphan_clr got=%b/%h exp=0/0", err_orphan_o, err_id_o); end
    $display("orphan: err=%b id=%h after clear", err_orphan_o, err_id_o);
  endtask

  task automatic test_drain();
    for (int k = 0; k < 2; k++) begin drive_req(1, 1); tick(); end
    drive_req(0, 0); drain_req_i = 1; tick();
    drive_req(1, 1);
    #1;
    n_chk++; if (req_ready_o !== 1'b0 || req_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_block got=%b/%b exp=0/0", req_ready_o, req_valid_o); end
    for (int k = 0; k < 2; k++) begin
      drive_rsp(1, 1, 1); tick();
      n_chk++; if (drain_ack_o !== 1'b0) begin n_fail++; $display("FAIL drain_early_ack k=%0d got=%b exp=0", k, drain_ack_o); end
    end
    drive_rsp(0, 1, 0); tick();
    n_chk++; if (drain_ack_o !== 1'b1 || req_ready_o !== 1'b0) begin n_fail++; $display("FAIL drain_ack got=%b/%b exp=1/0", drain_ack_o, req_ready_o); end
    $display("drain: ack=%b tot=%0d", drain_ack_o, tot_outst_o);
    drain_req_i = 0; tick();
    n_chk++; if (drain_ack_o !== 1'b0 || req_ready_o !== 1'b1) begin n_fail++; $display("FAIL drain_release got=%b/%b exp=0/1", drain_ack_o, req_ready_o); end
    tick();
    drive_req(0, 0);
    n_chk++; if (tot_outst_o !== 8'd1) begin n_fail++; $display("FAIL drain_resume_tot got=%0d exp=1", tot_outst_o); end
    drive_rsp(1, 1, 1); tick(); drive_rsp(0, 1, 0);
  endtask

  task automatic test_id_en();
    id_en_i[4] = 1'b0; drive_req(1, 4);
    #1;
    n_chk++; if (req_ready_o !== 1'b0 || req_valid_o !== 1'b0) begin n_fail++; $display("FAIL id_en_block got=%b/%b exp=0/0", req_ready_o, req_valid_o); end
    tick();
    id_en_i[4] = 1'b1;
    #1;
    n_chk++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL id_en_same_cycle got=%b exp=1", req_ready_o); end
    tick();
    drive_req(0, 0);
    for (int k = 0; k < 3; k++) begin drive_rsp(1, 0, 4); tick(); end
    drive_rsp(1, 1, 4); rsp_ready_i = 0; tick();
    n_chk++; if (tot_outst_o !== 8'd1) begin n_fail++; $display("FAIL id_en_nonlast got=%0d exp=1", tot_outst_o); end
    rsp_ready_i = 1; tick(); drive_rsp(0, 1, 0);
    n_chk++; if (tot_outst_o !== 8'd0 || err_orphan_o !== 1'b0) begin n_fail++; $display("FAIL id_en_last got=%0d/%b exp=0/0", tot_outst_o, err_orphan_o); end
    $display("id_en: tot=%0d after last beat", tot_outst_o);
  endtask

  task automatic test_random();
    bit exp_rdy, exp_vld;
    for (int c = 0; c < 600; c++) begin
      req_valid_i = 1'($urandom % 2);
      req_id_i    = IDW'($urandom_range(0, 3));
      req_ready_i = 1'(($urandom % 4) != 0);
      rsp_valid_i = 1'(($urandom % 3) == 0);
      rsp_ready_i = 1'(($urandom % 4) != 0);
      rsp_last_i  = 1'(($urandom % 3) != 0);
      rsp_id_i    = IDW'($urandom_range(0, 3));
      err_clr_i   = 1'(($urandom % 16) == 0);
      if (($urandom % 40) == 0) drain_req_i = ~drain_req_i;
      if (($urandom % 20) == 0) id_en_i[3:0] = 4'($urandom);
      #1;
      exp_rdy = req_ready_i && m_allow();
      exp_vld = req_valid_i && m_allow();
      n_chk++; if (req_ready_o !== exp_rdy || req_valid_o !== exp_vld) begin n_fail++; $display("FAIL rnd_gate c=%0d got=%b/%b exp=%b/%b", c, req_ready_o, req_valid_o, exp_rdy, exp_vld); end
      tick();
      n_chk++;
      if (tot_outst_o !== TOTW'(m_tot) || drain_ack_o !== (m_mode == 2) || err_orphan_o !== m_err || err_id_o !== IDW'(m_eid)) begin
        n_fail++;
        $display("FAIL rnd_state c=%0d got tot=%0d ack=%b err=%b id=%h exp tot=%0d ack=%b err=%b id=%h", c, tot_outst_o, drain_ack_o, err_orphan_o, err_id_o, m_tot, m_mode == 2, m_err, m_eid);
      end
      if (c % 100 == 0) $display("random: cycle %0d tot=%0d ack=%b err=%b", c, tot_outst_o, drain_ack_o, err_orphan_o);
    end
    idle(); drain_req_i = 0; id_en_i = '1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_same_id();
    test_orphan();
    test_drain();
    test_id_en();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
